// File: rtl/mmio_bus_if.sv
// Request/response and slave-side signal bundle for mmio_bus_ctrl.
// The controller takes the slave modport; the requesting agent takes master.
interface mmio_bus_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 4
);
   logic                      req_valid;
   logic [ADDR_W-1:0]         req_addr;
   logic [DATA_W-1:0]         req_wdata;
   logic                      req_wren;
   logic                      req_ready;
   logic                      rsp_valid;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      rsp_err;
   logic [NUM_SLV-1:0]        slv_sel;
   logic [NUM_SLV-1:0]        slv_wren;
   logic [ADDR_W-1:0]         slv_addr;
   logic [DATA_W-1:0]         slv_wdata;
   logic [NUM_SLV*DATA_W-1:0] slv_rddata;
   logic [NUM_SLV-1:0]        slv_ack;

   modport slave (
      input  req_valid, req_addr, req_wdata, req_wren, slv_rddata, slv_ack,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             slv_sel, slv_wren, slv_addr, slv_wdata
   );

   modport master (
      output req_valid, req_addr, req_wdata, req_wren, slv_rddata, slv_ack,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             slv_sel, slv_wren, slv_addr, slv_wdata
   );
endinterface

// File: rtl/mmio_bus_ctrl.sv
// Single-outstanding MMIO address decoder / bus controller with ack timeout.
// Optional macro BUS_ERR_CAPTURE_EN adds err_addr/err_count/err_clear error capture.
module mmio_bus_ctrl #(
   parameter int                        ADDR_W   = 32,
   parameter int                        DATA_W   = 32,
   parameter int                        NUM_SLV  = 4,
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h10000010, 32'h10000000,
                                                    32'h10010000, 32'h00400000},
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {32'hFFFFFFF0, 32'hFFFFFFF0,
                                                    32'hFFFF0000, 32'hFFC00000},
   parameter int                        TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst,
   mmio_bus_if.slave         bus
`ifdef BUS_ERR_CAPTURE_EN
   ,
   output logic [ADDR_W-1:0] err_addr,
   output logic [7:0]        err_count,
   input  logic              err_clear
`endif
);
   localparam int         SEL_W    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state_q, state_nx;

   logic [ADDR_W-1:0]  addr_p1;
   logic [DATA_W-1:0]  wdata_p1;
   logic               wren_p1;
   logic [SEL_W-1:0]   sel_p1;
   logic [7:0]         tmo_cnt;
   logic [DATA_W-1:0]  rdata_p2;
   logic               err_p2;

   logic               hit;
   logic [SEL_W-1:0]   hit_idx;
   logic               go_access;
   logic               ack_sel;
   logic               tmo_hit;
   logic [DATA_W-1:0]  rd_sel;
   logic [NUM_SLV-1:0] sel_onehot;

   // Downward scan so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if ((bus.req_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   assign go_access  = hit && (bus.req_addr[1:0] == 2'b00);
   assign ack_sel    = bus.slv_ack[sel_p1];
   assign rd_sel     = bus.slv_rddata[int'(sel_p1)*DATA_W +: DATA_W];
   assign tmo_hit    = (tmo_cnt == TMO_LAST);
   assign sel_onehot = NUM_SLV'(1) << sel_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE:    if (bus.req_valid) state_nx = go_access ? ACCESS : RESP;
         ACCESS:  if (ack_sel || tmo_hit) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request latch (p1) and response capture (p2); ack takes priority over timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_p1  <= '0;
         wdata_p1 <= '0;
         wren_p1  <= 1'b0;
         sel_p1   <= '0;
         tmo_cnt  <= '0;
         rdata_p2 <= '0;
         err_p2   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.req_valid) begin
               addr_p1  <= bus.req_addr;
               wdata_p1 <= bus.req_wdata;
               wren_p1  <= bus.req_wren;
               sel_p1   <= hit_idx;
               tmo_cnt  <= '0;
               rdata_p2 <= '0;
               err_p2   <= ~go_access;
            end
            ACCESS: begin
               if (ack_sel) begin
                  rdata_p2 <= wren_p1 ? '0 : rd_sel;
                  err_p2   <= 1'b0;
               end else if (tmo_hit) begin
                  rdata_p2 <= '0;
                  err_p2   <= 1'b1;
               end else begin
                  tmo_cnt  <= tmo_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = '0;
      bus.rsp_err   = 1'b0;
      bus.slv_sel   = '0;
      bus.slv_wren  = '0;
      case (state_q)
         IDLE:   bus.req_ready = ~rst;
         ACCESS: begin
            bus.slv_sel  = sel_onehot;
            bus.slv_wren = wren_p1 ? sel_onehot : '0;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = rdata_p2;
            bus.rsp_err   = err_p2;
         end
         default: ;
      endcase
   end

   assign bus.slv_addr  = (addr_p1 & ~SLV_MASK[int'(sel_p1)*ADDR_W +: ADDR_W]) >> 2;
   assign bus.slv_wdata = wdata_p1;

`ifdef BUS_ERR_CAPTURE_EN
   // Clear wins over a same-cycle error response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_addr  <= '0;
         err_count <= '0;
      end else if (err_clear) begin
         err_addr  <= '0;
         err_count <= '0;
      end else if (state_q == RESP && err_p2) begin
         err_addr  <= addr_p1;
         if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Randomized self-checking bench for mmio_bus_ctrl against a transaction-level model.
module tb_mmio_bus_ctrl;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int NUM_SLV = 4;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mmio_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV)) bus_if ();

`ifdef BUS_ERR_CAPTURE_EN
   logic [ADDR_W-1:0] err_addr;
   logic [7:0]        err_count;
   logic              err_clear;
   int                exp_ecnt  = 0;
   logic [ADDR_W-1:0] exp_eaddr = '0;

   mmio_bus_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if),
                      .err_addr(err_addr), .err_count(err_count), .err_clear(err_clear));
`else
   mmio_bus_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));
`endif

   logic [ADDR_W-1:0] base_a [NUM_SLV] = '{32'h00400000, 32'h10010000, 32'h10000000, 32'h10000010};
   logic [ADDR_W-1:0] mask_a [NUM_SLV] = '{32'hFFC00000, 32'hFFFF0000, 32'hFFFFFFF0, 32'hFFFFFFF0};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic int ref_decode(input logic [ADDR_W-1:0] a);
      for (int i = 0; i < NUM_SLV; i++)
         if ((a & mask_a[i]) == base_a[i]) return i;
      return -1;
   endfunction

   task automatic set_rd(input int sel, input logic [DATA_W-1:0] rdata);
      for (int s = 0; s < NUM_SLV; s++)
         bus_if.slv_rddata[s*DATA_W +: DATA_W] = (s == sel) ? rdata : DATA_W'($urandom);
   endtask

   // ack_at: ACCESS cycle (1-based) in which the target slave acks; > TIMEOUT means never.
   task automatic run_txn(input logic [ADDR_W-1:0] addr, input logic wren,
                          input logic [DATA_W-1:0] wdata, input int ack_at,
                          input logic [DATA_W-1:0] rdata);
      int                 sel, exp_lat, lat, bad;
      bit                 mapped;
      logic               exp_err, got_err;
      logic [DATA_W-1:0]  exp_rd, got_rd;
      logic [ADDR_W-1:0]  exp_off;
      logic [NUM_SLV-1:0] tmask, noise;
      sel     = ref_decode(addr);
      mapped  = (sel >= 0) && (addr[1:0] == 2'b00);
      tmask   = '0;
      exp_off = '0;
      if (mapped) begin
         tmask   = NUM_SLV'(1) << sel;
         exp_off = (addr & ~mask_a[sel]) >> 2;
      end
      if (!mapped) begin
         exp_lat = 1; exp_err = 1'b1; exp_rd = '0;
      end else if (ack_at <= TIMEOUT) begin
         exp_lat = ack_at + 1; exp_err = 1'b0; exp_rd = wren ? '0 : rdata;
      end else begin
         exp_lat = TIMEOUT + 1; exp_err = 1'b1; exp_rd = '0;
      end

      bus_if.req_valid = 1'b1;
      bus_if.req_addr  = addr;
      bus_if.req_wdata = wdata;
      bus_if.req_wren  = wren;
      bus_if.slv_ack   = NUM_SLV'($urandom);
      set_rd(mapped ? sel : -1, rdata);
      @(negedge clk);
      chk("req_ready_idle", bus_if.req_ready, 1);
      @(posedge clk); #1;
      bus_if.req_valid = 1'b0;
      bus_if.req_addr  = $urandom;
      bus_if.req_wdata = $urandom;
      bus_if.req_wren  = 1'($urandom_range(0, 1));

      lat = 0; bad = 0; got_err = 1'b0; got_rd = '0;
      for (int k = 1; k <= TIMEOUT + 8 && lat == 0; k++) begin
         noise = NUM_SLV'($urandom);
         if (k == exp_lat) bus_if.slv_ack = noise;
         else bus_if.slv_ack = (noise & ~tmask) | ((mapped && k == ack_at) ? tmask : '0);
         set_rd(mapped ? sel : -1, rdata);
         @(negedge clk);
         if (bus_if.rsp_valid) begin
            lat = k; got_err = bus_if.rsp_err; got_rd = bus_if.rsp_rdata;
         end else begin
            if (bus_if.slv_sel !== tmask) bad++;
            if (bus_if.slv_wren !== (wren ? tmask : '0)) bad++;
            if (mapped && (bus_if.slv_addr !== exp_off || bus_if.slv_wdata !== wdata)) bad++;
            if (bus_if.rsp_err !== 1'b0 || bus_if.rsp_rdata !== '0 || bus_if.req_ready !== 1'b0) bad++;
         end
         @(posedge clk); #1;
      end
      bus_if.slv_ack = '0;
      chk("rsp_latency", lat, exp_lat);
      chk("rsp_err", got_err, exp_err);
      chk("rsp_rdata", got_rd, exp_rd);
      chk("access_outputs", bad, 0);
      chk("rsp_one_cycle", {bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata}, 0);
`ifdef BUS_ERR_CAPTURE_EN
      if (exp_err) begin
         exp_ecnt  = (exp_ecnt < 255) ? exp_ecnt + 1 : 255;
         exp_eaddr = addr;
      end
      chk("err_count", err_count, exp_ecnt);
      chk("err_addr", err_addr, exp_eaddr);
`endif
   endtask

   task automatic rand_addr(output logic [ADDR_W-1:0] a);
      int s;
      s = $urandom_range(0, NUM_SLV - 1);
      a = base_a[s] | (ADDR_W'($urandom) & ~mask_a[s]);
      a[1:0] = 2'b00;
      case ($urandom_range(0, 9))
         0:       a = 32'h20000000 | (ADDR_W'($urandom) & 32'h0FFFFFFC);
         1:       a[1:0] = 2'($urandom_range(1, 3));
         default: ;
      endcase
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ADDR_W-1:0] a;
      int                seen;
      rst               = 1'b1;
      bus_if.req_valid  = 1'b0;
      bus_if.req_addr   = '0;
      bus_if.req_wdata  = '0;
      bus_if.req_wren   = 1'b0;
      bus_if.slv_ack    = '0;
      bus_if.slv_rddata = '0;
`ifdef BUS_ERR_CAPTURE_EN
      err_clear = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", bus_if.req_ready, 0);
      chk("rst_rsp", {bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata}, 0);
      chk("rst_slv_sel_wren", {bus_if.slv_sel, bus_if.slv_wren}, 0);
      chk("rst_slv_addr", bus_if.slv_addr, 0);
      chk("rst_slv_wdata", bus_if.slv_wdata, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      run_txn(32'h00400008, 1'b0, 32'h0, 1, 32'hDEADBEEF);
      run_txn(32'h10010004, 1'b1, 32'h0000005A, 3, 32'h12345678);
      run_txn(32'h10000000, 1'b0, 32'h0, TIMEOUT + 5, 32'h11111111);
      run_txn(32'h20000000, 1'b0, 32'h0, 1, 32'h22222222);
      run_txn(32'h00400002, 1'b0, 32'h0, 1, 32'h33333333);
      run_txn(32'h10000014, 1'b0, 32'h0, TIMEOUT, 32'hCAFEF00D);
      run_txn(32'h10000018, 1'b1, 32'hA5A5A5A5, TIMEOUT, 32'h44444444);

`ifdef BUS_ERR_CAPTURE_EN
      err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0;
      exp_ecnt  = 0;
      exp_eaddr = '0;
      chk("err_clear", {err_addr, err_count}, 0);
`endif

      // Reset pulsed in the middle of an access to a slave that never acks.
      bus_if.req_valid = 1'b1;
      bus_if.req_addr  = 32'h10000004;
      bus_if.req_wdata = 32'h00001234;
      bus_if.req_wren  = 1'b1;
      bus_if.slv_ack   = '0;
      @(negedge clk);
      @(posedge clk); #1;
      bus_if.req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("pre_rst_sel", bus_if.slv_sel, 4'b0100);
      rst = 1'b1;
      #1;
      chk("midrst_sel_wren", {bus_if.slv_sel, bus_if.slv_wren}, 0);
      chk("midrst_slv_addr", bus_if.slv_addr, 0);
      chk("midrst_slv_wdata", bus_if.slv_wdata, 0);
      chk("midrst_rsp_ready", {bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata, bus_if.req_ready}, 0);
      @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (k == 0) chk("ready_after_rst", bus_if.req_ready, 1);
         if (bus_if.rsp_valid) seen++;
      end
      chk("no_rsp_after_rst", seen, 0);
`ifdef BUS_ERR_CAPTURE_EN
      exp_ecnt  = 0;
      exp_eaddr = '0;
`endif

      for (int n = 0; n < 40; n++) begin
         rand_addr(a);
         run_txn(a, 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(1, TIMEOUT + 2), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
